// File: rtl/piano_pkg.sv
// Shared sizing, types and helpers for the note/voice scheduler.
package piano_pkg;

  localparam int NUM_NOTES  = 8;
  localparam int NUM_VOICES = 4;
  localparam int NOTE_W     = 3;
  localparam int AGE_W      = 8;
  localparam int VOICE_W    = $clog2(NUM_VOICES);

  typedef logic [NOTE_W-1:0]  note_idx_t;
  typedef logic [VOICE_W-1:0] voice_idx_t;
  typedef logic [AGE_W-1:0]   age_t;

  // Saturating increment so an old voice never wraps back to looking young.
  function automatic age_t age_sat_inc(input age_t a);
    return (a == {AGE_W{1'b1}}) ? a : a + age_t'(1);
  endfunction

endpackage

// File: rtl/first_one_sel.sv
// Lowest-set-bit selector: reports whether any bit is set and the index of
// the lowest one. Shared by pending-note service and free-voice search.
module first_one_sel #(
  parameter  int W  = 8,
  localparam int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  i_vec,
  output logic          o_valid,
  output logic [IW-1:0] o_index
);

  // Scan from the top down so the last hit (lowest index) wins.
  always_comb begin
    o_valid = |i_vec;
    o_index = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (i_vec[i]) o_index = IW'(i);
    end
  end

endmodule

// File: rtl/note_voice_scheduler.sv
// Note-to-voice scheduler: detects key edges, queues presses, services the
// lowest pending note each cycle onto the lowest free voice, and frees voices
// on release. Optional voice stealing (oldest voice takes the new note when
// all are busy) is compiled in with `define VOICE_STEAL_EN.
module note_voice_scheduler
  import piano_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_NOTES-1:0]         key,
  output logic [NUM_VOICES-1:0]        voice_active,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
  output logic [NUM_NOTES-1:0]         note_en,
  output logic                         overflow
);

  logic [NUM_NOTES-1:0]  r_key_q;
  logic [NUM_NOTES-1:0]  r_pending;
  logic [NUM_VOICES-1:0] r_voice_active;
  note_idx_t             r_voice_note [NUM_VOICES];
  age_t                  r_age        [NUM_VOICES];
  logic                  r_overflow;

  logic [NUM_NOTES-1:0]  w_press;
  logic [NUM_NOTES-1:0]  w_release;
  logic [NUM_NOTES-1:0]  w_cand;
  logic [NUM_NOTES-1:0]  w_svc_onehot;
  logic [NUM_VOICES-1:0] w_clear;
  logic [NUM_VOICES-1:0] w_active_rel;
  logic [NUM_VOICES-1:0] w_free;
  logic                  w_svc_valid;
  note_idx_t             w_svc_idx;
  logic                  w_free_valid;
  voice_idx_t            w_free_idx;
  voice_idx_t            w_steal_idx;
  voice_idx_t            w_alloc_voice;
  logic                  w_alloc_valid;
  logic                  w_ovf_nxt;

  assign w_press   = key & ~r_key_q;
  assign w_release = ~key & r_key_q;

  // Releases are resolved before allocation so a freed voice can be reused
  // in the same cycle, and a release cancels a same-cycle service of its note.
  always_comb begin
    w_clear = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      w_clear[v] = r_voice_active[v] & w_release[r_voice_note[v]];
    end
  end

  assign w_active_rel = r_voice_active & ~w_clear;
  assign w_free       = ~w_active_rel;
  assign w_cand       = (r_pending | w_press) & ~w_release;

  first_one_sel #(.W(NUM_NOTES)) u_note_sel (
    .i_vec   (w_cand),
    .o_valid (w_svc_valid),
    .o_index (w_svc_idx)
  );

  first_one_sel #(.W(NUM_VOICES)) u_voice_sel (
    .i_vec   (w_free),
    .o_valid (w_free_valid),
    .o_index (w_free_idx)
  );

  // One-hot of the note being serviced, used to retire it from pending.
  always_comb begin
    w_svc_onehot = '0;
    if (w_svc_valid) w_svc_onehot[w_svc_idx] = 1'b1;
  end

`ifdef VOICE_STEAL_EN
  age_t w_best_age;

  // Oldest voice wins; strict compare keeps the lowest index on ties.
  always_comb begin
    w_best_age  = r_age[0];
    w_steal_idx = '0;
    for (int v = 1; v < NUM_VOICES; v++) begin
      if (r_age[v] > w_best_age) begin
        w_best_age  = r_age[v];
        w_steal_idx = voice_idx_t'(v);
      end
    end
  end

  assign w_alloc_valid = w_svc_valid;
`else
  assign w_steal_idx   = '0;
  assign w_alloc_valid = w_svc_valid & w_free_valid;
`endif

  assign w_alloc_voice = w_free_valid ? w_free_idx : w_steal_idx;
  assign w_ovf_nxt     = w_svc_valid & ~w_free_valid;

  // Key history, pending queue, overflow pulse and per-voice state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_key_q        <= '0;
      r_pending      <= '0;
      r_voice_active <= '0;
      r_overflow     <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        r_voice_note[v] <= '0;
        r_age[v]        <= '0;
      end
    end else begin
      r_key_q    <= key;
      r_pending  <= w_cand & ~w_svc_onehot;
      r_overflow <= w_ovf_nxt;
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (w_alloc_valid && (w_alloc_voice == voice_idx_t'(v))) begin
          r_voice_active[v] <= 1'b1;
          r_voice_note[v]   <= w_svc_idx;
          r_age[v]          <= '0;
        end else begin
          r_voice_active[v] <= w_active_rel[v];
          if (w_alloc_valid && w_active_rel[v]) r_age[v] <= age_sat_inc(r_age[v]);
        end
      end
    end
  end

  // Flatten voice notes and build the tone-generator enables.
  always_comb begin
    note_en = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      voice_note[v*NOTE_W +: NOTE_W] = r_voice_note[v];
      if (r_voice_active[v]) note_en[r_voice_note[v]] = 1'b1;
    end
  end

  assign voice_active = r_voice_active;
  assign overflow     = r_overflow;

endmodule

// File: tb/tb_note_voice_scheduler.sv
// Directed bench for note_voice_scheduler; expected outputs for each edge are
// queued when the stimulus is applied and checked after the edge.
// Expectations follow VOICE_STEAL_EN when the bench is built with it.
module tb_note_voice_scheduler;

  logic        clk;
  logic        rst_n;
  logic [7:0]  key;
  logic [3:0]  voice_active;
  logic [11:0] voice_note;
  logic [7:0]  note_en;
  logic        overflow;

  typedef struct packed {
    logic [3:0]  act;
    logic [11:0] note;
    logic [7:0]  en;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  note_voice_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key          (key),
    .voice_active (voice_active),
    .voice_note   (voice_note),
    .note_en      (note_en),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input string fld,
                       input logic [11:0] obs, input logic [11:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, expv);
    end
  endtask

  // Apply key, queue the expectation for the coming edge, then check it.
  task automatic step(input string tag, input logic [7:0] k,
                      input logic [3:0] act, input logic [11:0] note,
                      input logic [7:0] en, input logic ovf);
    exp_t e;
    exp_t g;
    key = k;
    e.act = act; e.note = note; e.en = en; e.ovf = ovf;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_cmp++; n_fail++;
      $error("FAIL %s.queue observed=empty expected=entry", tag);
    end else begin
      g = sb.pop_front();
      check(tag, "active",   {8'h0, voice_active}, {8'h0, g.act});
      check(tag, "note",     voice_note,           g.note);
      check(tag, "note_en",  {4'h0, note_en},      {4'h0, g.en});
      check(tag, "overflow", {11'h0, overflow},    {11'h0, g.ovf});
    end
  endtask

  initial begin
    rst_n = 1'b0;
    key   = 8'h00;
    step("reset0", 8'h00, 4'h0, 12'h000, 8'h00, 1'b0);
    step("reset1", 8'h00, 4'h0, 12'h000, 8'h00, 1'b0);
    rst_n = 1'b1;

    // Lone press and release
    step("lone_press", 8'h01, 4'h1, 12'h000, 8'h01, 1'b0);
    step("lone_rel",   8'h00, 4'h0, 12'h000, 8'h00, 1'b0);

    // Four simultaneous presses serviced on consecutive edges
    step("fill_v0", 8'h0F, 4'h1, 12'h000, 8'h01, 1'b0);
    step("fill_v1", 8'h0F, 4'h3, 12'h008, 8'h03, 1'b0);
    step("fill_v2", 8'h0F, 4'h7, 12'h088, 8'h07, 1'b0);
    step("fill_v3", 8'h0F, 4'hF, 12'h688, 8'h0F, 1'b0);

    // Fifth note with all voices busy
`ifdef VOICE_STEAL_EN
    step("busy_press", 8'h8F, 4'hF, 12'h68F, 8'h8E, 1'b1);
    step("busy_after", 8'h8F, 4'hF, 12'h68F, 8'h8E, 1'b0);
    step("rel_all",    8'h00, 4'h0, 12'h68F, 8'h00, 1'b0);
    step("pre_svc0",   8'h03, 4'h1, 12'h688, 8'h01, 1'b0);
`else
    step("busy_press", 8'h8F, 4'hF, 12'h688, 8'h0F, 1'b1);
    step("busy_after", 8'h8F, 4'hF, 12'h688, 8'h0F, 1'b0);
    step("rel_all",    8'h00, 4'h0, 12'h688, 8'h00, 1'b0);
    step("pre_svc0",   8'h03, 4'h1, 12'h688, 8'h01, 1'b0);
`endif

    // Note 1 released while still pending: never allocated
    step("pre_rel1", 8'h01, 4'h1, 12'h688, 8'h01, 1'b0);
    step("pre_hold", 8'h01, 4'h1, 12'h688, 8'h01, 1'b0);
    step("pre_rel0", 8'h00, 4'h0, 12'h688, 8'h00, 1'b0);

    // Voice freed and reallocated at the same edge
    step("reuse_a",   8'h01, 4'h1, 12'h688, 8'h01, 1'b0);
    step("reuse_b",   8'h02, 4'h1, 12'h689, 8'h02, 1'b0);
    step("reuse_rel", 8'h00, 4'h0, 12'h689, 8'h00, 1'b0);

    // Keys held through reset release
    rst_n = 1'b0;
    step("rst_hold0", 8'hFF, 4'h0, 12'h000, 8'h00, 1'b0);
    step("rst_hold1", 8'hFF, 4'h0, 12'h000, 8'h00, 1'b0);
    rst_n = 1'b1;
    step("held_v0", 8'hFF, 4'h1, 12'h000, 8'h01, 1'b0);
    step("held_v1", 8'hFF, 4'h3, 12'h008, 8'h03, 1'b0);
    step("held_v2", 8'hFF, 4'h7, 12'h088, 8'h07, 1'b0);
    step("held_v3", 8'hFF, 4'hF, 12'h688, 8'h0F, 1'b0);
`ifdef VOICE_STEAL_EN
    step("held_n4", 8'hFF, 4'hF, 12'h68C, 8'h1E, 1'b1);
`else
    step("held_n4", 8'hFF, 4'hF, 12'h688, 8'h0F, 1'b1);
`endif

    // Mid-run reset clears everything, including the overflow pulse
    rst_n = 1'b0;
    step("mid_rst", 8'hFF, 4'h0, 12'h000, 8'h00, 1'b0);
    rst_n = 1'b1;
    step("post_rst", 8'h00, 4'h0, 12'h000, 8'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
